// File: rtl/pix_capture_ctrl.sv
// Pixel-domain capture sequencer: arms on request, aligns to a frame boundary, gates a fixed
// number of whole frames (or runs continuously) and checks line/frame geometry.
module pix_capture_ctrl #(
  parameter int unsigned PD_W  = 20,
  parameter int unsigned CNT_W = 12
) (
  input  logic             clk_pixel_i,
  input  logic             reset_pixel_i,
  input  logic             arm_i,
  input  logic             abort_i,
  input  logic [7:0]       frame_cnt_i,
  input  logic [CNT_W-1:0] exp_width_i,
  input  logic [CNT_W-1:0] exp_height_i,
  input  logic             fv_i,
  input  logic             lv_i,
  input  logic [PD_W-1:0]  pd_i,
  output logic             pix_valid_o,
  output logic [PD_W-1:0]  pix_data_o,
  output logic             sof_o,
  output logic             eof_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [7:0]       frame_idx_o,
  output logic             err_width_o,
  output logic             err_height_o
);

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CntMax = '1;

  typedef enum logic [2:0] {
    StIdle,
    StWaitFvLow,
    StWaitFvHigh,
    StCapture,
    StDone
  } state_e;

  state_e           state_q;
  logic             fv_q, lv_q;
  logic [CNT_W-1:0] pix_cnt_q, line_cnt_q;
  logic             pix_valid_q, sof_q, eof_q, busy_q, done_q;
  logic [PD_W-1:0]  pix_data_q;
  logic [7:0]       frame_idx_q;
  logic             err_width_q, err_height_q;

  logic             fv_rise, fv_fall, lv_fall, pix_gate, last_frame;
  logic [CNT_W-1:0] pix_cnt_inc, line_cnt_inc, line_cnt_eff;
  logic [7:0]       frame_idx_inc;

  always_comb begin
    fv_rise       = fv_i & ~fv_q;
    fv_fall       = ~fv_i & fv_q;
    lv_fall       = ~lv_i & lv_q;
    pix_gate      = fv_i & lv_i;
    // Counters stick at all-ones so an oversize line never aliases a small expected value.
    pix_cnt_inc   = (pix_cnt_q == CntMax) ? pix_cnt_q : pix_cnt_q + CntOne;
    line_cnt_inc  = (line_cnt_q == CntMax) ? line_cnt_q : line_cnt_q + CntOne;
    line_cnt_eff  = lv_fall ? line_cnt_inc : line_cnt_q;
    frame_idx_inc = frame_idx_q + 8'd1;
    last_frame    = (frame_cnt_i != 8'd0) && (frame_idx_inc == frame_cnt_i);
  end

  always_ff @(posedge clk_pixel_i) begin
    if (reset_pixel_i) begin
      state_q      <= StIdle;
      fv_q         <= 1'b0;
      lv_q         <= 1'b0;
      pix_cnt_q    <= '0;
      line_cnt_q   <= '0;
      pix_valid_q  <= 1'b0;
      pix_data_q   <= '0;
      sof_q        <= 1'b0;
      eof_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      frame_idx_q  <= 8'd0;
      err_width_q  <= 1'b0;
      err_height_q <= 1'b0;
    end else begin
      fv_q        <= fv_i;
      lv_q        <= lv_i;
      pix_valid_q <= 1'b0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
      done_q      <= 1'b0;

      if (abort_i && (state_q != StIdle)) begin
        // Abort drops everything in flight; frame index and error flags are kept for software.
        state_q <= StIdle;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          StIdle: begin
            busy_q <= 1'b0;
            if (arm_i && !abort_i) begin
              frame_idx_q  <= 8'd0;
              err_width_q  <= 1'b0;
              err_height_q <= 1'b0;
              pix_cnt_q    <= '0;
              line_cnt_q   <= '0;
              busy_q       <= 1'b1;
              state_q      <= fv_i ? StWaitFvLow : StWaitFvHigh;
            end
          end

          StWaitFvLow: begin
            busy_q <= 1'b1;
            if (!fv_i) begin
              state_q <= StWaitFvHigh;
            end
          end

          StWaitFvHigh: begin
            busy_q <= 1'b1;
            if (fv_rise) begin
              state_q    <= StCapture;
              sof_q      <= 1'b1;
              line_cnt_q <= '0;
              pix_cnt_q  <= lv_i ? CntOne : '0;
              if (lv_i) begin
                pix_valid_q <= 1'b1;
                pix_data_q  <= pd_i;
              end
            end
          end

          StCapture: begin
            busy_q <= 1'b1;
            if (pix_gate) begin
              pix_valid_q <= 1'b1;
              pix_data_q  <= pd_i;
              pix_cnt_q   <= pix_cnt_inc;
            end
            if (lv_fall) begin
              if (pix_cnt_q != exp_width_i) begin
                err_width_q <= 1'b1;
              end
              line_cnt_q <= line_cnt_inc;
              pix_cnt_q  <= '0;
            end
            if (fv_fall) begin
              if (line_cnt_eff != exp_height_i) begin
                err_height_q <= 1'b1;
              end
              frame_idx_q <= frame_idx_inc;
              eof_q       <= 1'b1;
              state_q     <= last_frame ? StDone : StWaitFvHigh;
            end
          end

          StDone: begin
            // Busy stays up through the done pulse and drops the cycle after.
            done_q  <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= StIdle;
          end

          default: begin
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

  assign pix_valid_o  = pix_valid_q;
  assign pix_data_o   = pix_data_q;
  assign sof_o        = sof_q;
  assign eof_o        = eof_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign frame_idx_o  = frame_idx_q;
  assign err_width_o  = err_width_q;
  assign err_height_o = err_height_q;

endmodule

// File: tb/tb_pix_capture_ctrl.sv
// Self-checking bench for pix_capture_ctrl: a frame-level behavioural model checked every cycle,
// plus directed scenarios with hand-computed pulse counts and flag values.
module tb_pix_capture_ctrl;

  localparam int PdW  = 20;
  localparam int CntW = 12;
  localparam int CntMaxI = (1 << CntW) - 1;

  logic            clk_pixel_i = 1'b0;
  logic            reset_pixel_i;
  logic            arm_i, abort_i;
  logic [7:0]      frame_cnt_i;
  logic [CntW-1:0] exp_width_i, exp_height_i;
  logic            fv_i, lv_i;
  logic [PdW-1:0]  pd_i;
  logic            pix_valid_o;
  logic [PdW-1:0]  pix_data_o;
  logic            sof_o, eof_o, busy_o, done_o;
  logic [7:0]      frame_idx_o;
  logic            err_width_o, err_height_o;

  pix_capture_ctrl #(.PD_W(PdW), .CNT_W(CntW)) dut (
    .clk_pixel_i  (clk_pixel_i),
    .reset_pixel_i(reset_pixel_i),
    .arm_i        (arm_i),
    .abort_i      (abort_i),
    .frame_cnt_i  (frame_cnt_i),
    .exp_width_i  (exp_width_i),
    .exp_height_i (exp_height_i),
    .fv_i         (fv_i),
    .lv_i         (lv_i),
    .pd_i         (pd_i),
    .pix_valid_o  (pix_valid_o),
    .pix_data_o   (pix_data_o),
    .sof_o        (sof_o),
    .eof_o        (eof_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .frame_idx_o  (frame_idx_o),
    .err_width_o  (err_width_o),
    .err_height_o (err_height_o)
  );

  always #5 clk_pixel_i = ~clk_pixel_i;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model (frame-level, integer counts) ----------------
  bit             m_wait_low, m_wait_rise, m_cap, m_finish, m_pfv, m_plv;
  bit             m_rise, m_fall, m_lfall, m_active;
  int             m_px, m_ln, m_frames;
  bit             e_valid, e_sof, e_eof, e_busy, e_done, e_errw, e_errh;
  logic [PdW-1:0] e_data;
  int             edge_n = 0;
  int             abort_edge = 32'h7fffffff;

  function automatic int sat(input int v);
    return (v > CntMaxI) ? CntMaxI : v;
  endfunction

  always @(posedge clk_pixel_i) begin
    edge_n++;
    if (abort_i) abort_edge = edge_n;
    if (reset_pixel_i) begin
      {m_wait_low, m_wait_rise, m_cap, m_finish, m_pfv, m_plv} = '0;
      m_px = 0; m_ln = 0; m_frames = 0;
      {e_valid, e_sof, e_eof, e_busy, e_done, e_errw, e_errh} = '0;
      e_data = '0;
    end else begin
      m_rise   = fv_i && !m_pfv;
      m_fall   = !fv_i && m_pfv;
      m_lfall  = !lv_i && m_plv;
      m_active = m_wait_low || m_wait_rise || m_cap || m_finish;
      {e_valid, e_sof, e_eof, e_done} = '0;
      if (abort_i && m_active) begin
        {m_wait_low, m_wait_rise, m_cap, m_finish} = '0;
        e_busy = 0;
      end else if (m_finish) begin
        m_finish = 0; e_done = 1; e_busy = 1;
      end else if (!m_active) begin
        e_busy = 0;
        if (arm_i && !abort_i) begin
          m_frames = 0; e_errw = 0; e_errh = 0; m_px = 0; m_ln = 0; e_busy = 1;
          if (fv_i) m_wait_low = 1; else m_wait_rise = 1;
        end
      end else begin
        e_busy = 1;
        if (m_wait_low) begin
          if (!fv_i) begin m_wait_low = 0; m_wait_rise = 1; end
        end else if (m_wait_rise) begin
          if (m_rise) begin
            m_wait_rise = 0; m_cap = 1; e_sof = 1; m_ln = 0; m_px = lv_i ? 1 : 0;
            if (lv_i) begin e_valid = 1; e_data = pd_i; end
          end
        end else begin
          if (fv_i && lv_i) begin e_valid = 1; e_data = pd_i; m_px++; end
          if (m_lfall) begin
            if (sat(m_px) != int'(exp_width_i)) e_errw = 1;
            m_ln++; m_px = 0;
          end
          if (m_fall) begin
            if (sat(m_ln) != int'(exp_height_i)) e_errh = 1;
            m_frames++; e_eof = 1; m_cap = 0;
            if (frame_cnt_i != 0 && (m_frames % 256) == int'(frame_cnt_i)) m_finish = 1;
            else m_wait_rise = 1;
          end
        end
      end
      m_pfv = fv_i; m_plv = lv_i;
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk_pixel_i) begin
    chk("pix_valid", 32'(pix_valid_o), 32'(e_valid));
    chk("pix_data", 32'(pix_data_o), 32'(e_data));
    chk("sof", 32'(sof_o), 32'(e_sof));
    chk("eof", 32'(eof_o), 32'(e_eof));
    chk("busy", 32'(busy_o), 32'(e_busy));
    chk("done", 32'(done_o), 32'(e_done));
    chk("frame_idx", 32'(frame_idx_o), 32'(m_frames % 256));
    chk("err_width", 32'(err_width_o), 32'(e_errw));
    chk("err_height", 32'(err_height_o), 32'(e_errh));
  end

  // Pulse counters for the literal scenario checks.
  int n_valid = 0, n_sof = 0, n_eof = 0, n_done = 0, n_late = 0;
  always @(negedge clk_pixel_i) begin
    if (pix_valid_o) n_valid++;
    if (sof_o) n_sof++;
    if (eof_o) n_eof++;
    if (done_o) n_done++;
    if (pix_valid_o && edge_n > abort_edge) n_late++;
  end

  // ---------------- stimulus ----------------
  task automatic drv(input bit fv, input bit lv, input bit arm, input bit abort);
    fv_i = fv; lv_i = lv; arm_i = arm; abort_i = abort;
    pd_i = pd_i + 20'h00013;
    @(negedge clk_pixel_i);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drv(0, 0, 0, 0);
  endtask

  // One frame: fv rises with lv low, 1-cycle line gaps, fv falls either with the last line
  // (simul) or one cycle after it. arm/abort fire at frame-relative step arm_at/abort_at.
  task automatic frame(input int w, input int h, input int short_line, input bit simul,
                       input int arm_at, input int abort_at);
    int k;
    int n;
    k = 0;
    drv(1, 0, k == arm_at, k == abort_at); k++;
    for (int l = 0; l < h; l++) begin
      n = (l == short_line) ? w - 1 : w;
      for (int p = 0; p < n; p++) begin
        drv(1, 1, k == arm_at, k == abort_at); k++;
      end
      if (l < h - 1 || !simul) begin
        drv(1, 0, k == arm_at, k == abort_at); k++;
      end
    end
    drv(0, 0, k == arm_at, k == abort_at);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pix_valid"}, 32'(pix_valid_o), 32'd0);
    chk({tag, "_pix_data"}, 32'(pix_data_o), 32'd0);
    chk({tag, "_sof"}, 32'(sof_o), 32'd0);
    chk({tag, "_eof"}, 32'(eof_o), 32'd0);
    chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    chk({tag, "_done"}, 32'(done_o), 32'd0);
    chk({tag, "_frame_idx"}, 32'(frame_idx_o), 32'd0);
    chk({tag, "_err_width"}, 32'(err_width_o), 32'd0);
    chk({tag, "_err_height"}, 32'(err_height_o), 32'd0);
  endtask

  int s_valid, s_sof, s_eof, s_done, s_late;
  task automatic snap();
    s_valid = n_valid; s_sof = n_sof; s_eof = n_eof; s_done = n_done; s_late = n_late;
  endtask

  initial begin
    reset_pixel_i = 1; arm_i = 0; abort_i = 0; fv_i = 0; lv_i = 0; pd_i = '0;
    frame_cnt_i = 8'd2; exp_width_i = 12'd8; exp_height_i = 12'd4;
    idle(2);
    chk_all_zero("reset");
    reset_pixel_i = 0;
    idle(2);

    // Nominal: two of three frames captured.
    snap();
    drv(0, 0, 1, 0);
    chk("nom_busy_after_arm", 32'(busy_o), 32'd1);
    for (int f = 0; f < 3; f++) frame(8, 4, -1, 0, -1, -1);
    idle(3);
    chk("nom_valid_count", 32'(n_valid - s_valid), 32'd64);
    chk("nom_sof_count", 32'(n_sof - s_sof), 32'd2);
    chk("nom_eof_count", 32'(n_eof - s_eof), 32'd2);
    chk("nom_done_count", 32'(n_done - s_done), 32'd1);
    chk("nom_frame_idx", 32'(frame_idx_o), 32'd2);
    chk("nom_errs", 32'({err_width_o, err_height_o}), 32'd0);
    chk("nom_busy_end", 32'(busy_o), 32'd0);

    // Arm in the third line of a frame: that frame is skipped.
    frame_cnt_i = 8'd1;
    snap();
    frame(8, 4, -1, 0, 21, -1);
    frame(8, 4, -1, 0, -1, -1);
    idle(3);
    chk("mid_valid_count", 32'(n_valid - s_valid), 32'd32);
    chk("mid_sof_count", 32'(n_sof - s_sof), 32'd1);
    chk("mid_done_count", 32'(n_done - s_done), 32'd1);
    chk("mid_frame_idx", 32'(frame_idx_o), 32'd1);

    // Geometry errors: short line, then a tall frame; both flags stick.
    frame_cnt_i = 8'd3;
    drv(0, 0, 1, 0);
    frame(8, 4, 1, 0, -1, -1);
    chk("geo_err_width_set", 32'(err_width_o), 32'd1);
    chk("geo_err_height_clear", 32'(err_height_o), 32'd0);
    frame(8, 5, -1, 0, -1, -1);
    chk("geo_err_height_set", 32'(err_height_o), 32'd1);
    frame(8, 4, -1, 1, -1, -1);
    idle(3);
    chk("geo_errs_sticky", 32'({err_width_o, err_height_o}), 32'd3);
    chk("geo_frame_idx", 32'(frame_idx_o), 32'd3);

    // Re-arm clears flags; lv and fv falling together on a matching frame is clean.
    frame_cnt_i = 8'd1;
    drv(0, 0, 1, 0);
    chk("rearm_errs_cleared", 32'({err_width_o, err_height_o}), 32'd0);
    frame(8, 4, -1, 1, -1, -1);
    idle(3);
    chk("simul_errs", 32'({err_width_o, err_height_o}), 32'd0);
    chk("simul_frame_idx", 32'(frame_idx_o), 32'd1);

    // Abort mid-line in frame 1 of 3.
    frame_cnt_i = 8'd3;
    drv(0, 0, 1, 0);
    snap();
    frame(8, 4, -1, 0, -1, 13);
    idle(2);
    chk("abort_late_valid", 32'(n_late - s_late), 32'd0);
    chk("abort_eof_count", 32'(n_eof - s_eof), 32'd0);
    chk("abort_done_count", 32'(n_done - s_done), 32'd0);
    chk("abort_frame_idx", 32'(frame_idx_o), 32'd0);
    chk("abort_busy", 32'(busy_o), 32'd0);

    // Arm together with abort in idle: stays idle.
    drv(0, 0, 1, 1);
    idle(1);
    chk("arm_abort_busy", 32'(busy_o), 32'd0);

    // Continuous: 300 frames wrap the index to 44 with no done.
    frame_cnt_i = 8'd0; exp_width_i = 12'd2; exp_height_i = 12'd2;
    drv(0, 0, 1, 0);
    snap();
    for (int f = 0; f < 300; f++) frame(2, 2, -1, f[0], -1, -1);
    idle(2);
    chk("cont_frame_idx", 32'(frame_idx_o), 32'd44);
    chk("cont_done_count", 32'(n_done - s_done), 32'd0);
    chk("cont_eof_count", 32'(n_eof - s_eof), 32'd300);
    chk("cont_errs", 32'({err_width_o, err_height_o}), 32'd0);
    chk("cont_busy", 32'(busy_o), 32'd1);

    // Reset mid-frame.
    drv(1, 0, 0, 0);
    drv(1, 1, 0, 0);
    reset_pixel_i = 1;
    drv(1, 1, 0, 0);
    chk_all_zero("midreset");
    reset_pixel_i = 0;
    idle(3);
    chk("post_reset_busy", 32'(busy_o), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
